// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: request and register-bank write bundle
// for the round-robin register write arbiter.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 32
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int SW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_lock;
    logic [NUM_REQ*AW-1:0]    req_addr;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REGS-1:0]      wr_en;
    logic [WIDTH-1:0]         wr_data;
    logic [SW-1:0]            wr_src;
    logic                     err_addr;

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, wr_en, wr_data, wr_src, err_addr
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, wr_en, wr_data, wr_src, err_addr
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write port arbiter with lock bursts.
// Optional REG_ARB_PRIO0_EN gives requester 0 fixed priority in ARB.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 32,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int SW      = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    reg_write_arbiter_if.slave bus
);
    typedef enum logic [0:0] {ARB, LOCK} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       ptr_q, ptr_d;
    logic [SW-1:0]       own_q, own_d;
    logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
    logic [WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [SW-1:0]       wr_src_q, wr_src_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  ready;
    logic [SW-1:0]       sel;
    logic                hit;
    logic                xfer;
    int                  j;
    logic [AW-1:0]       sel_addr;
    logic [WIDTH-1:0]    sel_data;
    logic [NUM_REGS-1:0] dec;

    function automatic logic [SW-1:0] nxt(input logic [SW-1:0] x);
        return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
    endfunction

    // Grant: owner only in LOCK, else first valid from ptr upward
    always_comb begin
        ready = '0;
        sel   = '0;
        hit   = 1'b0;
        j     = 0;
        if (state_q == LOCK) begin
            ready[own_q] = bus.req_valid[own_q];
            sel          = own_q;
        end else begin
`ifdef REG_ARB_PRIO0_EN
            if (bus.req_valid[0]) begin
                ready[0] = 1'b1;
                hit      = 1'b1;
            end
`endif
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (int'(ptr_q) + k) % NUM_REQ;
                if (!hit && bus.req_valid[j]) begin
                    ready[j] = 1'b1;
                    sel      = SW'(j);
                    hit      = 1'b1;
                end
            end
        end
    end

    assign xfer     = |ready;
    assign sel_addr = bus.req_addr[int'(sel)*AW +: AW];
    assign sel_data = bus.req_data[int'(sel)*WIDTH +: WIDTH];

    // One-hot decode; out-of-range addresses decode to zero
    always_comb begin
        dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (sel_addr == AW'(r)) dec[r] = 1'b1;
        end
    end

    // FSM next state plus round-robin pointer and owner updates
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        unique case (state_q)
            ARB: begin
                if (xfer) begin
                    if (bus.req_lock[sel]) begin
                        state_d = LOCK;
                        own_d   = sel;
                    end else begin
                        ptr_d = nxt(sel);
                    end
                end
            end
            LOCK: begin
                if (!bus.req_valid[own_q] || !bus.req_lock[own_q]) begin
                    state_d = ARB;
                    ptr_d   = nxt(own_q);
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Write strobe/data generation for the register bank
    always_comb begin
        wr_en_d   = '0;
        err_d     = 1'b0;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        if (xfer) begin
            wr_en_d   = dec;
            err_d     = ~|dec;
            wr_data_d = sel_data;
            wr_src_d  = sel;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            own_q     <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_src    = wr_src_q;
    assign bus.err_addr  = err_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed vectors with a write scoreboard.
// Expectations adapt when REG_ARB_PRIO0_EN is defined.
`ifdef REG_ARB_PRIO0_EN
`define PICK(rr, p) (p)
`else
`define PICK(rr, p) (rr)
`endif
module tb_reg_write_arbiter;
    localparam int NREQ = 4;
    localparam int NREG = 6;
    localparam int W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(NREQ), .NUM_REGS(NREG), .WIDTH(W)) bus ();

    reg_write_arbiter #(.NUM_REQ(NREQ), .NUM_REGS(NREG), .WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [5:0]  en;
        logic [31:0] data;
        logic [1:0]  src;
        logic        err;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  addr_t[4];
    logic [31:0] data_t[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l);
        bus.req_valid = v;
        bus.req_lock  = l;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*3 +: 3]  = addr_t[i];
            bus.req_data[i*32 +: 32] = data_t[i];
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] l,
                        input logic [3:0] g, input string nm);
        wr_t e;
        @(posedge clk);
        #1;
        drive(v, l);
        #1;
        chk(nm, 64'(bus.req_ready), 64'(g));
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                e.en   = (int'(addr_t[i]) < NREG) ? (6'd1 << addr_t[i]) : 6'd0;
                e.data = data_t[i];
                e.src  = 2'(i);
                e.err  = (int'(addr_t[i]) >= NREG);
                sb.push_back(e);
            end
        end
    endtask

    // Monitor: every strobe or error pulse must match the oldest expectation
    always @(negedge clk) begin
        wr_t a, e;
        if (!rst && (bus.wr_en != '0 || bus.err_addr)) begin
            a = '{en: bus.wr_en, data: bus.wr_data, src: bus.wr_src, err: bus.err_addr};
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h expected none", a);
            end else begin
                e = sb.pop_front();
                chk("write", 64'(a), 64'(e));
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            addr_t[i] = 3'(i);
            data_t[i] = 32'hA0 + 32'(i);
        end
        drive(4'b0000, 4'b0000);
        #12;
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
        chk("rst_wr_src", 64'(bus.wr_src), 64'd0);
        chk("rst_err", 64'(bus.err_addr), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;

        // Round robin, all valid, no lock
        step(4'b1111, 4'b0000, `PICK(4'b0001, 4'b0001), "rr_g0");
        step(4'b1111, 4'b0000, `PICK(4'b0010, 4'b0001), "rr_g1");
        step(4'b1111, 4'b0000, `PICK(4'b0100, 4'b0001), "rr_g2");
        step(4'b1111, 4'b0000, `PICK(4'b1000, 4'b0001), "rr_g3");
        step(4'b1111, 4'b0000, `PICK(4'b0001, 4'b0001), "rr_g4");

        // Requester 2 burst of three while others stay valid
        step(`PICK(4'b1111, 4'b1110), 4'b0000, 4'b0010, "pre_lock");
        step(`PICK(4'b1111, 4'b1110), 4'b0100, 4'b0100, "lock_a");
        step(`PICK(4'b1111, 4'b1110), 4'b0100, 4'b0100, "lock_b");
        step(`PICK(4'b1111, 4'b1110), 4'b0000, 4'b0100, "lock_c");
        step(`PICK(4'b1111, 4'b1110), 4'b0000, 4'b1000, "after_lock");

        // Owner 1 drops valid: release without a transfer
        step(4'b0010, 4'b0010, 4'b0010, "lock1");
        step(4'b1101, 4'b0000, 4'b0000, "lock1_drop");
        step(4'b1100, 4'b0000, 4'b0100, "after_drop");
        step(4'b0000, 4'b0000, 4'b0000, "idle_a");

        // Out-of-range address, then top valid address
        addr_t[0] = 3'd7;
        data_t[0] = 32'h55;
        step(4'b0001, 4'b0000, 4'b0001, "bad_addr");
        step(4'b0000, 4'b0000, 4'b0000, "idle_b");
        step(4'b0000, 4'b0000, 4'b0000, "idle_c");
        chk("hold_en", 64'(bus.wr_en), 64'd0);
        chk("hold_err", 64'(bus.err_addr), 64'd0);
        chk("hold_data", 64'(bus.wr_data), 64'h55);
        chk("hold_src", 64'(bus.wr_src), 64'd0);
        addr_t[0] = 3'd0;
        data_t[0] = 32'hA0;
        addr_t[1] = 3'd5;
        step(4'b0010, 4'b0000, 4'b0010, "top_addr");
        addr_t[1] = 3'd1;
        step(4'b0100, 4'b0000, 4'b0100, "set_ptr3");

        // Requesters 0 and 3 with ptr at 3
        step(4'b1001, 4'b0000, `PICK(4'b1000, 4'b0001), "p_a");
        step(4'b1001, 4'b0000, `PICK(4'b0001, 4'b0001), "p_b");
        step(4'b1001, 4'b0000, `PICK(4'b1000, 4'b0001), "p_c");
        step(4'b1001, 4'b0000, `PICK(4'b0001, 4'b0001), "p_d");
        step(4'b0000, 4'b0000, 4'b0000, "idle_d");

        // Asynchronous reset in the middle of a burst
        step(4'b0010, 4'b0010, 4'b0010, "burst_a");
        step(4'b0010, 4'b0010, 4'b0010, "burst_b");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("arst_wr_data", 64'(bus.wr_data), 64'd0);
        chk("arst_wr_src", 64'(bus.wr_src), 64'd0);
        sb.delete();
        drive(4'b0000, 4'b0000);
        #1 rst = 1'b0;
        step(4'b1111, 4'b0000, 4'b0001, "post_rst");
        step(4'b0000, 4'b0000, 4'b0000, "idle_e");

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`undef PICK

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write-port arbiter that shares a bank of `NUM_REGS` enable-gated registers among `NUM_REQ` requesters. Each cycle it grants at most one valid request and converts it into a registered one-hot write strobe plus data for the register bank. It also supports a lock (burst) mode, so one requester can hold the port across consecutive writes. It sits between the pipeline/control agents and the architectural register bank; the bank's `en`/`d` inputs are driven directly from `wr_en`/`wr_data`.

## Interface
- `NUM_REQ`, default 4: number of requesters (≥2).
- `NUM_REGS`, default 8: number of registers in the bank (≥2, need not be a power of two).
- `WIDTH`, default 32: data width.
- `AW` (derived, `$clog2(NUM_REGS)`): address width. `SW` (derived, `$clog2(NUM_REQ)`): source-ID width.

Ports:
- `clk`  in  1  — the single clock; all state is on its rising edge.
- `rst`  in  1  — asynchronous reset, active-high.
- `req_valid`  in  NUM_REQ  — request i has a write pending.
- `req_lock`  in  NUM_REQ  — request i asks to keep ownership after this transfer.
- `req_addr`  in  NUM_REQ*AW  — packed target register index; slice i belongs to request i.
- `req_data`  in  NUM_REQ*WIDTH  — packed write data; slice i belongs to request i.
- `req_ready`  out  NUM_REQ  — one-hot grant, combinational; transfer i occurs when `req_valid[i] && req_ready[i]`.
- `wr_en`  out  NUM_REGS  — registered one-hot write strobe to the bank.
- `wr_data`  out  WIDTH  — registered write data.
- `wr_src`  out  SW  — registered index of the requester that issued the current `wr_en`.
- `err_addr`  out  1  — registered one-cycle pulse: the accepted request had `addr ≥ NUM_REGS`.

## Operation
- State is the FSM {ARB, LOCK}, plus the round-robin pointer `ptr` (SW bits) and the lock owner `own` (SW bits).
- **ARB:**
  - Grant the first valid requester, searching from `ptr` upward modulo `NUM_REQ`.
  - `req_ready` is all-zero when no request is valid.
  - `req_ready` is only ever asserted on a requester whose `req_valid` is high.
- **Transfer from requester i in ARB:**
  - If `req_lock[i]=1`: go to LOCK with `own=i`; `ptr` is unchanged.
  - If `req_lock[i]=0`: `ptr ← (i+1) mod NUM_REQ`.
- **LOCK:**
  - `req_ready` = `req_valid[own]` on bit `own`; all other bits are 0.
  - A transfer with `req_lock[own]=0` returns the FSM to ARB, `ptr ← own+1 mod NUM_REQ`.
  - `req_valid[own]=0` for a cycle also releases: return to ARB with the same `ptr` update, no transfer.
- **Write generation:**
  - On a transfer with `addr < NUM_REGS`, the next cycle shows `wr_en = 1<<addr`, `wr_data = data`, `wr_src = i`.
  - On a transfer with `addr ≥ NUM_REGS`, the next cycle shows `wr_en = 0`, `err_addr = 1`, `wr_src = i`, and `wr_data` updated.
  - With no transfer, the next cycle shows `wr_en = 0` and `err_addr = 0`; `wr_data` and `wr_src` hold their values.
- `wr_en` is never more than one-hot.
- Requesters must hold `addr`, `data` and `lock` stable while valid and not ready. `req_valid` may drop before grant; this is not an error.

## Timing
- Reset values: FSM = ARB, `ptr = 0`, `own = 0`, `wr_en = 0`, `wr_data = 0`, `wr_src = 0`, `err_addr = 0`.
- Reset effects are immediate (asynchronous).
- Grant latency is 0 cycles: `req_ready` is combinational from `req_valid`, state and `ptr`.
- Write latency is 1 cycle: the transfer in cycle N gives `wr_en` in cycle N+1, and the register updates at the end of N+1.
- Maximum throughput is one write per cycle; back-to-back transfers produce a `wr_en` pulse on every cycle.
- Fairness without lock: every continuously valid requester is granted within `NUM_REQ` transfers.
- Lock has no timeout; the owner bounds its burst length.
- Reset asserted mid-burst drops LOCK and clears any pending `wr_en`.
- A transfer in the cycle `rst` deasserts is honoured normally.

## Configuration
- `REG_ARB_PRIO0_EN` defined:
  - In ARB, requester 0 wins whenever `req_valid[0]=1`, regardless of `ptr`.
  - The other requesters are round-robin among themselves.
  - LOCK ownership is still never pre-empted.
- `REG_ARB_PRIO0_EN` undefined: pure round-robin as described above.

## Test plan
- Reset, then all four requesters valid continuously with no lock (addrs 0..3, data 0xA0..0xA3) -> grants are 0,1,2,3,0; `wr_en` is 0x01,0x02,0x04,0x08,0x01, each one cycle after its grant.
- Requester 2 transfers three times with `lock=1,1,0` while requesters 0, 1 and 3 stay valid -> three consecutive grants to 2; `wr_src=2` for 3 cycles; the next grant is 3.
- Requester 1 in LOCK drops `req_valid` for one cycle -> FSM returns to ARB with no `wr_en` pulse; the next grant goes to requester 2 if valid.
- `NUM_REGS=6`, requester 0 writes addr 7 with data 0x55 -> `wr_en=0` and `err_addr=1` for one cycle; no register changes.
- `rst` pulsed asynchronously mid-cycle during a locked burst -> `wr_en` and `wr_data` read 0 immediately; after release, the first grant goes to requester 0.
- With `REG_ARB_PRIO0_EN`, requesters 0 and 3 continuously valid and `ptr=3` -> requester 0 is granted every cycle; without the macro the grants alternate 3,0,3,0.
